// File: rtl/pulse_sync_pkg.sv
// Shared constants and helpers for the multi-channel event synchronizer.
package pulse_sync_pkg;

    localparam int unsigned IN_MODE_TOGGLE  = 0;
    localparam int unsigned IN_MODE_LEVEL   = 1;
    localparam int unsigned SYNC_STAGES_MIN = 2;

    // Saturation value of an unsigned counter of the given width.
    function automatic int unsigned cnt_max(input int unsigned width);
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage

// File: rtl/sync_chain_bit.sv
// Single-bit multi-flop synchronizer into the clk domain.
module sync_chain_bit #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_async,
    output logic q_sync
);

    (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_async};
        end
    end

    assign q_sync = sync_q[STAGES-1];

endmodule

// File: rtl/pulse_sync_rx_mc.sv
// Multi-channel event synchronizer: per-channel pulse, saturating counter, sticky overflow.
// Define PULSE_SYNC_ACK_EN to register ack_toggle from the delayed synchronized value.
module pulse_sync_rx_mc
    import pulse_sync_pkg::*;
#(
    parameter int unsigned CH_NUM      = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned IN_MODE     = IN_MODE_TOGGLE
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CH_NUM-1:0]         evt_in,
    input  logic [CH_NUM-1:0]         clr_cnt,
    output logic [CH_NUM-1:0]         pulse_out,
    output logic [CH_NUM*CNT_W-1:0]   evt_cnt,
    output logic [CH_NUM-1:0]         cnt_ovf,
    output logic [CH_NUM-1:0]         ack_toggle
);

    localparam int unsigned STAGES = (SYNC_STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN : SYNC_STAGES;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));

    for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
        logic             s_last;
        logic             d_q;
        logic             evt_edge_c;
        logic             pulse_q;
        logic             ovf_q;
        logic [CNT_W-1:0] cnt_q;

        sync_chain_bit #(
            .STAGES (STAGES)
        ) u_sync (
            .clk     (clk),
            .rst_n   (rst_n),
            .d_async (evt_in[i]),
            .q_sync  (s_last)
        );

        if (IN_MODE == IN_MODE_TOGGLE) begin : g_toggle
            assign evt_edge_c = s_last ^ d_q;
        end else begin : g_level
            assign evt_edge_c = s_last & ~d_q;
        end

        // Delay flop and registered edge pulse.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                d_q     <= 1'b0;
                pulse_q <= 1'b0;
            end else begin
                d_q     <= s_last;
                pulse_q <= evt_edge_c;
            end
        end

        // Clear takes priority, then the same-cycle pulse is counted on top of it.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q <= '0;
                ovf_q <= 1'b0;
            end else if (clr_cnt[i]) begin
                cnt_q <= pulse_q ? CNT_W'(1) : '0;
                ovf_q <= 1'b0;
            end else if (pulse_q) begin
                if (cnt_q == CNT_MAX) begin
                    ovf_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end
        end

        assign pulse_out[i]                = pulse_q;
        assign evt_cnt[i*CNT_W +: CNT_W]   = cnt_q;
        assign cnt_ovf[i]                  = ovf_q;

`ifdef PULSE_SYNC_ACK_EN
        logic ack_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                ack_q <= 1'b0;
            end else begin
                ack_q <= d_q;
            end
        end

        assign ack_toggle[i] = ack_q;
`endif
    end

`ifndef PULSE_SYNC_ACK_EN
    assign ack_toggle = '0;
`endif

endmodule

// File: tb/tb_pulse_sync_rx_mc.sv
// Scoreboard bench for pulse_sync_rx_mc: one toggle-mode and one level-mode instance.
module tb_pulse_sync_rx_mc;
    import pulse_sync_pkg::*;

`ifdef PULSE_SYNC_ACK_EN
    localparam int unsigned SS     = 3;
    localparam bit          ACK_ON = 1'b1;
`else
    localparam int unsigned SS     = 2;
    localparam bit          ACK_ON = 1'b0;
`endif
    localparam int unsigned CH = 4;
    localparam int unsigned CW = 3;

    typedef struct {
        int              cyc;
        logic [CH-1:0]   mask;
        logic [CH*CW-1:0] cnt;
        logic [CH-1:0]   ovf;
        logic [CH-1:0]   ack;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [CH-1:0] evt_t = '0, evt_l = '0, clr_t = '0, clr_l = '0;
    logic [CH-1:0] pulse_t, ovf_t, ack_t, pulse_l, ovf_l, ack_l;
    logic [CH*CW-1:0] cnt_t, cnt_l;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    exp_t q0[$];
    exp_t q1[$];
    int   cm [2][CH];
    logic ovm[2][CH];

    logic [CH-1:0]    po[2], ov[2], ak[2];
    logic [CH*CW-1:0] cn[2];
    assign po[0] = pulse_t;  assign po[1] = pulse_l;
    assign ov[0] = ovf_t;    assign ov[1] = ovf_l;
    assign ak[0] = ack_t;    assign ak[1] = ack_l;
    assign cn[0] = cnt_t;    assign cn[1] = cnt_l;

    pulse_sync_rx_mc #(
        .CH_NUM(CH), .SYNC_STAGES(SS), .CNT_W(CW), .IN_MODE(IN_MODE_TOGGLE)
    ) dut_t (
        .clk(clk), .rst_n(rst_n), .evt_in(evt_t), .clr_cnt(clr_t),
        .pulse_out(pulse_t), .evt_cnt(cnt_t), .cnt_ovf(ovf_t), .ack_toggle(ack_t)
    );

    pulse_sync_rx_mc #(
        .CH_NUM(CH), .SYNC_STAGES(SS), .CNT_W(CW), .IN_MODE(IN_MODE_LEVEL)
    ) dut_l (
        .clk(clk), .rst_n(rst_n), .evt_in(evt_l), .clr_cnt(clr_l),
        .pulse_out(pulse_l), .evt_cnt(cnt_l), .cnt_ovf(ovf_l), .ack_toggle(ack_l)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++)
            for (int c = 0; c < CH; c++) begin
                cm[k][c]  = 0;
                ovm[k][c] = 1'b0;
            end
    endtask

    // Expected pulse for DUT k: updates the count model and queues the response.
    task automatic push(input int k, input logic [CH-1:0] mask, input logic [CH-1:0] lvl, input bit clr);
        exp_t e;
        for (int c = 0; c < CH; c++) begin
            if (mask[c]) begin
                if (clr) begin
                    cm[k][c]  = 1;
                    ovm[k][c] = 1'b0;
                end else if (cm[k][c] == 7) begin
                    ovm[k][c] = 1'b1;
                end else begin
                    cm[k][c]++;
                end
            end
        end
        e.cyc  = cyc + int'(SS) + 1;
        e.mask = mask;
        for (int c = 0; c < CH; c++) begin
            e.cnt[c*CW +: CW] = CW'(cm[k][c]);
            e.ovf[c]          = ovm[k][c];
        end
        e.ack = ACK_ON ? lvl : '0;
        if (k == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic tog(input logic [CH-1:0] mask);
        evt_t = evt_t ^ mask;
        push(0, mask, evt_t, 1'b0);
    endtask

    // Monitor: pops an expectation per pulse, checks counters/ack the following cycle.
    bit   pend[2] = '{1'b0, 1'b0};
    exp_t pe[2];
    always @(negedge clk) begin
        exp_t e;
        bit   have;
        if (!rst_n) begin
            pend[0] = 1'b0;
            pend[1] = 1'b0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (pend[k]) begin
                    chk($sformatf("d%0d evt_cnt", k), 32'(cn[k]), 32'(pe[k].cnt));
                    chk($sformatf("d%0d cnt_ovf", k), 32'(ov[k]), 32'(pe[k].ovf));
                    chk($sformatf("d%0d ack_toggle", k), 32'(ak[k]), 32'(pe[k].ack));
                    pend[k] = 1'b0;
                end
                if (po[k] != '0) begin
                    have = 1'b0;
                    if (k == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
                    if (k == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
                    if (!have) begin
                        chk($sformatf("d%0d unexpected pulse", k), 32'(po[k]), 32'd0);
                    end else begin
                        chk($sformatf("d%0d pulse mask", k), 32'(po[k]), 32'(e.mask));
                        chk($sformatf("d%0d pulse cycle", k), 32'(cyc), 32'(e.cyc));
                        pe[k]   = e;
                        pend[k] = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        model_reset();
        tick(3);
        chk("reset pulse_t", 32'(pulse_t), 32'd0);
        chk("reset cnt_t",   32'(cnt_t),   32'd0);
        chk("reset ovf_t",   32'(ovf_t),   32'd0);
        chk("reset ack_t",   32'(ack_t),   32'd0);
        chk("reset pulse_l", 32'(pulse_l), 32'd0);
        chk("reset cnt_l",   32'(cnt_l),   32'd0);
        rst_n = 1'b1;
        tick(4);

        // single toggle on ch0
        tog(4'b0001);
        tick(SS + 4);

        // level held high: one pulse on rise, none on fall
        evt_l[1] = 1'b1;
        push(1, 4'b0010, evt_l, 1'b0);
        tick(20);
        evt_l[1] = 1'b0;
        tick(SS + 4);
        chk("level ch1 count", 32'(cnt_l[5:3]), 32'd1);

        // saturate ch2 with 9 events
        repeat (9) begin
            tog(4'b0100);
            tick(4);
        end
        tick(SS);
        chk("sat ch2 count", 32'(cnt_t[8:6]), 32'd7);
        chk("sat ch2 ovf",   32'(ovf_t[2]),   32'd1);

        // clear coincident with a pulse
        evt_t = evt_t ^ 4'b0100;
        push(0, 4'b0100, evt_t, 1'b1);
        tick(SS + 1);
        clr_t = 4'b0100;
        tick(1);
        clr_t = '0;
        tick(3);
        chk("clr+pulse ch2 count", 32'(cnt_t[8:6]), 32'd1);
        chk("clr+pulse ch2 ovf",   32'(ovf_t[2]),   32'd0);

        // all channels at once
        tog(4'b1111);
        tick(SS + 4);
        chk("all ch0 count", 32'(cnt_t[2:0]), 32'd2);

        // plain clear on ch0
        clr_t = 4'b0001;
        tick(1);
        clr_t = '0;
        cm[0][0] = 0;
        tick(1);
        chk("clr ch0 count", 32'(cnt_t[2:0]), 32'd0);

        // reset with a ch3 toggle in flight
        evt_t = evt_t ^ 4'b1000;
        tick(1);
        rst_n = 1'b0;
        evt_t = '0;
        model_reset();
        tick(2);
        rst_n = 1'b1;
        tick(SS + 4);
        chk("post-reset cnt_t", 32'(cnt_t), 32'd0);
        chk("post-reset ovf_t", 32'(ovf_t), 32'd0);

        // release with inputs already high
        rst_n = 1'b0;
        evt_t = 4'b1000;
        evt_l = 4'b0001;
        model_reset();
        tick(2);
        rst_n = 1'b1;
        push(0, 4'b1000, evt_t, 1'b0);
        push(1, 4'b0001, evt_l, 1'b0);
        tick(SS + 6);

        chk("q0 drained", 32'(q0.size()), 32'd0);
        chk("q1 drained", 32'(q1.size()), 32'd0);
        if (!ACK_ON) begin
            chk("ack_t idle", 32'(ack_t), 32'd0);
            chk("ack_l idle", 32'(ack_l), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
